sys_bus_nslv: RTL and testbench

Parametrised single-master system bus, the registered successor to the fixed four-slave combinational decoder. It sits between the CPU load/store port and NSLV peripheral slaves (IMEM read port, DMEM, GPIO, UART, PWM, encoder, …). Every slave gets a full valid/ready handshake. A per-access timeout, decode-error responses and sticky error capture let the CPU detect and recover from unmapped addresses or hung slaves instead of stalling forever.

---
 rtl/sys_bus_pkg.sv | 24 ++
 rtl/sys_bus_tmo.sv | 38 +++
 rtl/sys_bus_nslv.sv | 141 ++++++++++++++
 tb/tb_sys_bus_nslv.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_bus_pkg.sv
// Shared definitions for the parametrised single-master system bus.
// State encoding, default address map fields and the error-count helper.
package sys_bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
  localparam int unsigned SEL_HI_DEF   = 31;
  localparam int unsigned SEL_LO_DEF   = 28;

  localparam int unsigned SLV_IMEM = 0;
  localparam int unsigned SLV_DMEM = 1;
  localparam int unsigned SLV_GPIO = 2;
  localparam int unsigned SLV_UART = 3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? 8'hFF : val + 8'd1;
  endfunction

endpackage

// File: rtl/sys_bus_tmo.sv
// Access timeout counter. expire is registered and is high in the ACCESS cycle
// in which the count reaches limit-1; limit = 0 keeps expire low.
module sys_bus_tmo #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // Compare the next count so the flag lines up with the cycle it describes.
    expire_d = (limit != '0) && (clr || en) && (cnt_d == limit - CNT_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      expire <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      expire <= expire_d;
    end
  end

endmodule

// File: rtl/sys_bus_nslv.sv
// Registered single-master bus to NSLV slaves with decode-error responses,
// per-access timeout and sticky error capture.
module sys_bus_nslv
  import sys_bus_pkg::*;
#(
  parameter int unsigned          NSLV     = 4,
  parameter int unsigned          DATA_W   = 32,
  parameter int unsigned          SEL_HI   = SEL_HI_DEF,
  parameter int unsigned          SEL_LO   = SEL_LO_DEF,
  parameter int unsigned          TMO_CYC  = 255,
  parameter logic [DATA_W-1:0]    ERR_DATA = DATA_W'(ERR_DATA_DEF)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   m_valid,
  input  logic [31:0]            m_addr,
  input  logic                   m_wen,
  input  logic [DATA_W-1:0]      m_wdata,
  input  logic [DATA_W/8-1:0]    m_wmask,
  output logic                   m_ready,
  output logic [DATA_W-1:0]      m_rdata,
  output logic                   m_err,
  output logic [NSLV-1:0]        s_valid,
  output logic [31:0]            s_addr,
  output logic                   s_wen,
  output logic [DATA_W-1:0]      s_wdata,
  output logic [DATA_W/8-1:0]    s_wmask,
  input  logic [NSLV*DATA_W-1:0] s_rdata,
  input  logic [NSLV-1:0]        s_ready,
  input  logic                   err_clr,
  output logic                   err_irq,
  output logic [31:0]            err_addr,
  output logic [7:0]             err_cnt
);

  localparam int unsigned SEL_W = SEL_HI - SEL_LO + 1;
  localparam int unsigned TMO_W = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC + 1);

  state_e            state;
  logic [SEL_W-1:0]  idx;
  logic              dec_ok;
  logic [NSLV-1:0]   onehot;
  logic [DATA_W-1:0] rd_sel;
  logic              rdy_sel;
  logic              tmo_clr, tmo_en, expire;

  assign idx    = m_addr[SEL_HI:SEL_LO];
  assign dec_ok = 32'(idx) < NSLV;

  // s_valid doubles as the latched select while in ACCESS.
  always_comb begin
    onehot = '0;
    rd_sel = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      onehot[i] = (32'(idx) == i);
      if (s_valid[i]) rd_sel = rd_sel | s_rdata[i*DATA_W +: DATA_W];
    end
    rdy_sel = |(s_ready & s_valid);
  end

  assign tmo_clr = (state == StIdle) && m_valid && dec_ok;
  assign tmo_en  = (state == StAccess);

  sys_bus_tmo #(
    .CNT_W (TMO_W)
  ) u_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .limit  (TMO_W'(TMO_CYC)),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= StIdle;
      m_ready  <= 1'b0;
      m_err    <= 1'b0;
      m_rdata  <= '0;
      s_valid  <= '0;
      s_addr   <= '0;
      s_wen    <= 1'b0;
      s_wdata  <= '0;
      s_wmask  <= '0;
      err_irq  <= 1'b0;
      err_addr <= '0;
      err_cnt  <= '0;
    end else begin
      m_ready <= 1'b0;
      m_err   <= 1'b0;
      if (err_clr) begin
        err_irq <= 1'b0;
        err_cnt <= '0;
      end
      // Error capture below is assigned later so it overrides a concurrent clear.
      case (state)
        StIdle: begin
          if (m_valid) begin
            s_addr <= m_addr;
            if (dec_ok) begin
              s_wen   <= m_wen;
              s_wdata <= m_wdata;
              s_wmask <= m_wen ? m_wmask : '0;
              s_valid <= onehot;
              state   <= StAccess;
            end else begin
              m_ready  <= 1'b1;
              m_err    <= 1'b1;
              m_rdata  <= ERR_DATA;
              err_addr <= m_addr;
              err_irq  <= 1'b1;
              err_cnt  <= err_clr ? 8'd1 : sat_inc8(err_cnt);
              state    <= StDone;
            end
          end
        end
        StAccess: begin
          if (rdy_sel) begin
            s_valid <= '0;
            m_ready <= 1'b1;
            m_rdata <= s_wen ? '0 : rd_sel;
            state   <= StDone;
          end else if (expire) begin
            s_valid  <= '0;
            m_ready  <= 1'b1;
            m_err    <= 1'b1;
            m_rdata  <= ERR_DATA;
            err_addr <= s_addr;
            err_irq  <= 1'b1;
            err_cnt  <= err_clr ? 8'd1 : sat_inc8(err_cnt);
            state    <= StDone;
          end
        end
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_bus_nslv.sv
// Directed self-checking bench for sys_bus_nslv (NSLV=4, TMO_CYC=8).
module tb_sys_bus_nslv;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         m_valid = 1'b0;
  logic [31:0]  m_addr = '0;
  logic         m_wen = 1'b0;
  logic [31:0]  m_wdata = '0;
  logic [3:0]   m_wmask = '0;
  logic         m_ready;
  logic [31:0]  m_rdata;
  logic         m_err;
  logic [3:0]   s_valid;
  logic [31:0]  s_addr;
  logic         s_wen;
  logic [31:0]  s_wdata;
  logic [3:0]   s_wmask;
  logic [127:0] s_rdata = '0;
  logic [3:0]   s_ready = '0;
  logic         err_clr = 1'b0;
  logic         err_irq;
  logic [31:0]  err_addr;
  logic [7:0]   err_cnt;

  int checks = 0;
  int errors = 0;

  sys_bus_nslv #(
    .NSLV    (4),
    .DATA_W  (32),
    .SEL_HI  (31),
    .SEL_LO  (28),
    .TMO_CYC (8),
    .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m_valid (m_valid),
    .m_addr  (m_addr),
    .m_wen   (m_wen),
    .m_wdata (m_wdata),
    .m_wmask (m_wmask),
    .m_ready (m_ready),
    .m_rdata (m_rdata),
    .m_err   (m_err),
    .s_valid (s_valid),
    .s_addr  (s_addr),
    .s_wen   (s_wen),
    .s_wdata (s_wdata),
    .s_wmask (s_wmask),
    .s_rdata (s_rdata),
    .s_ready (s_ready),
    .err_clr (err_clr),
    .err_irq (err_irq),
    .err_addr(err_addr),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc();
    cyc();
    checks++; if ({m_ready, m_err, err_irq, s_wen} !== 4'b0) begin errors++;
      $display("FAIL reset_flags: got %b want 0000", {m_ready, m_err, err_irq, s_wen}); end
    checks++; if ({s_valid, s_wmask} !== 8'h00) begin errors++;
      $display("FAIL reset_svalid_mask: got %h want 00", {s_valid, s_wmask}); end
    checks++; if ({m_rdata, s_addr, s_wdata, err_addr, err_cnt} !== 136'h0) begin errors++;
      $display("FAIL reset_data: got %h want 0", {m_rdata, s_addr, s_wdata, err_addr, err_cnt}); end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_read();
    m_valid = 1'b1; m_addr = 32'h1000_0010; m_wen = 1'b0;
    m_wdata = 32'hFFFF_FFFF; m_wmask = 4'hF;
    s_rdata = {32'h0, 32'h0, 32'h1234_5678, 32'h0}; s_ready = 4'b0010;
    cyc();
    checks++; if (s_valid !== 4'b0010) begin errors++;
      $display("FAIL read_svalid: got %b want 0010", s_valid); end
    checks++; if (s_wmask !== 4'h0) begin errors++;
      $display("FAIL read_wmask: got %h want 0", s_wmask); end
    checks++; if (m_ready !== 1'b0) begin errors++;
      $display("FAIL read_early_ready: got %b want 0", m_ready); end
    cyc();
    checks++; if ({m_ready, m_err} !== 2'b10) begin errors++;
      $display("FAIL read_done: ready/err got %b want 10", {m_ready, m_err}); end
    checks++; if (m_rdata !== 32'h1234_5678) begin errors++;
      $display("FAIL read_data: got %h want 12345678", m_rdata); end
    checks++; if (s_valid !== 4'b0000) begin errors++;
      $display("FAIL read_svalid_drop: got %b want 0000", s_valid); end
    m_valid = 1'b0; s_ready = 4'b0000;
    cyc();
    checks++; if (m_ready !== 1'b0) begin errors++;
      $display("FAIL read_pulse_len: got %b want 0", m_ready); end
  endtask

  task automatic test_write_wait();
    m_valid = 1'b1; m_addr = 32'h3000_0000; m_wen = 1'b1;
    m_wdata = 32'h0000_0041; m_wmask = 4'hF; s_ready = 4'b0000;
    s_rdata = {32'h5555_5555, 32'h0, 32'h0, 32'h0};
    cyc();
    for (int i = 1; i <= 6; i++) begin
      checks++;
      if ({s_valid, s_addr, s_wen, s_wdata, s_wmask, m_ready} !==
          {4'b1000, 32'h3000_0000, 1'b1, 32'h0000_0041, 4'hF, 1'b0}) begin
        errors++;
        $display("FAIL write_hold cycle %0d: got sv=%b a=%h we=%b wd=%h wm=%h rdy=%b", i,
                 s_valid, s_addr, s_wen, s_wdata, s_wmask, m_ready);
      end
      if (i == 6) s_ready = 4'b1000;
      cyc();
    end
    checks++; if ({m_ready, m_err} !== 2'b10) begin errors++;
      $display("FAIL write_done: ready/err got %b want 10", {m_ready, m_err}); end
    checks++; if (m_rdata !== 32'h0) begin errors++;
      $display("FAIL write_rdata: got %h want 0", m_rdata); end
    m_valid = 1'b0; s_ready = 4'b0000; m_wen = 1'b0;
    cyc();
  endtask

  task automatic test_decode_err();
    m_valid = 1'b1; m_addr = 32'h7000_0000; m_wen = 1'b0;
    cyc();
    checks++; if ({m_ready, m_err, s_valid} !== 6'b110000) begin errors++;
      $display("FAIL dec_resp: ready/err/svalid got %b want 110000", {m_ready, m_err, s_valid}); end
    checks++; if (m_rdata !== 32'hDEAD_BEEF) begin errors++;
      $display("FAIL dec_rdata: got %h want deadbeef", m_rdata); end
    checks++; if ({err_addr, err_cnt, err_irq} !== {32'h7000_0000, 8'd1, 1'b1}) begin errors++;
      $display("FAIL dec_capture: got addr=%h cnt=%0d irq=%b want 70000000/1/1",
               err_addr, err_cnt, err_irq); end
    m_valid = 1'b0;
    cyc();
    checks++; if (s_valid !== 4'b0000 || m_ready !== 1'b0) begin errors++;
      $display("FAIL dec_after: svalid=%b ready=%b want 0000/0", s_valid, m_ready); end
  endtask

  task automatic test_timeout();
    m_valid = 1'b1; m_addr = 32'h2000_0004; m_wen = 1'b0;
    s_ready = 4'b1011;  // unselected slaves ready, GPIO never
    cyc();
    for (int i = 1; i <= 8; i++) begin
      checks++; if ({s_valid, m_ready} !== 5'b01000) begin errors++;
        $display("FAIL tmo_access cycle %0d: svalid=%b ready=%b want 0100/0", i, s_valid, m_ready);
      end
      cyc();
    end
    checks++; if ({m_ready, m_err, s_valid} !== 6'b110000) begin errors++;
      $display("FAIL tmo_resp: ready/err/svalid got %b want 110000", {m_ready, m_err, s_valid}); end
    checks++; if ({m_rdata, err_addr, err_cnt} !== {32'hDEAD_BEEF, 32'h2000_0004, 8'd2}) begin
      errors++;
      $display("FAIL tmo_capture: rdata=%h addr=%h cnt=%0d want deadbeef/20000004/2",
               m_rdata, err_addr, err_cnt); end
    m_valid = 1'b0; s_ready = 4'b0000;
    cyc();
    // DMEM access afterwards must complete normally
    m_valid = 1'b1; m_addr = 32'h1000_0004;
    s_rdata = {32'h0, 32'h0, 32'hCAFE_F00D, 32'h0}; s_ready = 4'b0010;
    cyc();
    cyc();
    checks++; if ({m_ready, m_err, m_rdata} !== {2'b10, 32'hCAFE_F00D}) begin errors++;
      $display("FAIL tmo_recover: ready/err=%b rdata=%h want 10/cafef00d", {m_ready, m_err},
               m_rdata); end
    m_valid = 1'b0; s_ready = 4'b0000;
    cyc();
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    m_valid = 1'b1; m_addr = 32'h1000_0000; s_ready = 4'b0010;
    cyc();
    for (int i = 1; i <= 9; i++) begin
      if (m_ready === 1'b1) pulses++;
      cyc();
    end
    checks++; if (pulses !== 3) begin errors++;
      $display("FAIL b2b_rate: got %0d pulses want 3", pulses); end
    m_valid = 1'b0; s_ready = 4'b0000;
    cyc(); cyc(); cyc();
  endtask

  task automatic test_err_sat();
    for (int i = 0; i < 256; i++) begin
      m_valid = 1'b1; m_addr = 32'hF000_0000;
      cyc();
      m_valid = 1'b0;
      cyc();
    end
    checks++; if ({err_cnt, err_irq} !== {8'd255, 1'b1}) begin errors++;
      $display("FAIL sat_cnt: got cnt=%0d irq=%b want 255/1", err_cnt, err_irq); end
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    checks++; if ({err_cnt, err_irq} !== {8'd0, 1'b0}) begin errors++;
      $display("FAIL clr: got cnt=%0d irq=%b want 0/0", err_cnt, err_irq); end
    m_valid = 1'b1; m_addr = 32'h5000_0000; err_clr = 1'b1;
    cyc();
    err_clr = 1'b0; m_valid = 1'b0;
    checks++; if ({err_cnt, err_irq, err_addr} !== {8'd1, 1'b1, 32'h5000_0000}) begin errors++;
      $display("FAIL clr_vs_capture: got cnt=%0d irq=%b addr=%h want 1/1/50000000",
               err_cnt, err_irq, err_addr); end
    cyc();
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    m_valid = 1'b1; m_addr = 32'h2000_0008; m_wen = 1'b1; m_wdata = 32'hA5A5_0000;
    m_wmask = 4'h3; s_ready = 4'b0000;
    cyc();
    checks++; if (s_valid !== 4'b0100) begin errors++;
      $display("FAIL rst_mid_setup: svalid got %b want 0100", s_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({s_valid, s_wmask, s_wen, m_ready, m_err, err_irq} !== 12'h0) begin errors++;
      $display("FAIL rst_mid_flags: sv=%b wm=%h we=%b rdy=%b err=%b irq=%b want all 0",
               s_valid, s_wmask, s_wen, m_ready, m_err, err_irq); end
    checks++; if ({m_rdata, s_addr, s_wdata, err_addr, err_cnt} !== 136'h0) begin errors++;
      $display("FAIL rst_mid_data: got %h want 0", {m_rdata, s_addr, s_wdata, err_addr, err_cnt});
    end
    m_valid = 1'b0; m_wen = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (m_ready === 1'b1) pulses++;
      cyc();
    end
    checks++; if (pulses !== 0) begin errors++;
      $display("FAIL rst_mid_no_ready: got %0d pulses want 0", pulses); end
    m_valid = 1'b1; m_addr = 32'h1000_0008;
    s_rdata = {32'h0, 32'h0, 32'h0BAD_F00D, 32'h0}; s_ready = 4'b0010;
    cyc();
    cyc();
    checks++; if ({m_ready, m_err, m_rdata} !== {2'b10, 32'h0BAD_F00D}) begin errors++;
      $display("FAIL rst_mid_recover: ready/err=%b rdata=%h want 10/0badf00d", {m_ready, m_err},
               m_rdata); end
    m_valid = 1'b0; s_ready = 4'b0000;
    cyc();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_wait();
    test_decode_err();
    test_timeout();
    test_back_to_back();
    test_err_sat();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
